// File: rtl/switch_mcu_pkg.sv
// Purpose : shared types and constants for the switch MCU sequencer and its ALU op units.
// Latency : n/a (package only).
// Backpressure : n/a.
package switch_mcu_pkg;

    localparam int XLEN        = 32;
    localparam int CYCLE_W     = 4;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_NEXT   = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    // Instruction addresses must sit on a word boundary.
    function automatic logic is_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/switch_mcu_pc_reg.sv
// Purpose : program counter with sequential +4 advance, redirect latch and alignment check.
// Latency : redirect captured on the EXEC edge, applied on the NEXT edge; misaligned is combinational.
// Backpressure : none; the sequencer FSM decides when capture/commit fire.
// Ports: clk/rst (sync, active high); capture = EXEC cycle, commit = NEXT cycle;
//        wen/wdata = redirect request; pc = current PC; misaligned = latched target not word aligned.
module switch_mcu_pc_reg
    import switch_mcu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            capture,
    input  logic            commit,
    input  logic            wen,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] pc,
    output logic            misaligned
);

    logic            redir_vld;
    logic [XLEN-1:0] redir_tgt;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            redir_vld <= 1'b0;
            redir_tgt <= '0;
        end else begin
            // Every EXEC-cycle write overwrites the previous one: last write wins.
            if (capture && wen) begin
                redir_vld <= 1'b1;
                redir_tgt <= wdata;
            end
            if (commit) begin
                redir_vld <= 1'b0;
                if (!redir_vld) begin
                    pc <= pc + XLEN'(INSTR_BYTES);  // wraps naturally at 2^32
                end else if (is_aligned(redir_tgt[1:0])) begin
                    pc <= redir_tgt;
                end
                // misaligned target: PC holds, the FSM parks in FAULT
            end
        end
    end

    assign misaligned = redir_vld && !is_aligned(redir_tgt[1:0]);

endmodule

// File: rtl/switch_mcu_sequencer.sv
// Purpose : fetch/decode/execute control sequencer; drives exec enable and cycle count to the ALU units.
// Latency : ack at t -> cycle count 1 at t+2 -> NEXT at t+EXEC_CYCLES+2 -> next fetch request at t+EXEC_CYCLES+3.
// Backpressure : fetch request is held with a stable address until in_imem_ack; nothing else stalls.
// Ports: in_clk/in_rst clock and sync reset; in_run start/stop; out_imem_* / in_imem_* fetch handshake;
//        out_instr latched instruction; out_exec_en/out_cycle_cnt execute strobes; in_pc_wen/in_pc_wdata
//        redirect; out_pc current PC; out_fault sticky misaligned-redirect flag.
module switch_mcu_sequencer
    import switch_mcu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
    parameter int              EXEC_CYCLES = 4              // legal range 4..15
) (
    input  logic               in_clk,
    input  logic               in_rst,
    input  logic               in_run,
    output logic               out_imem_req,
    output logic [XLEN-1:0]    out_imem_addr,
    input  logic               in_imem_ack,
    input  logic [XLEN-1:0]    in_imem_rdata,
    output logic [XLEN-1:0]    out_instr,
    output logic               out_exec_en,
    output logic [CYCLE_W-1:0] out_cycle_cnt,
    input  logic               in_pc_wen,
    input  logic [XLEN-1:0]    in_pc_wdata,
    output logic [XLEN-1:0]    out_pc,
    output logic               out_fault
);

    localparam logic [CYCLE_W-1:0] LAST_CNT = CYCLE_W'(EXEC_CYCLES);

    state_t             state;
    state_t             state_nxt;
    logic [CYCLE_W-1:0] cnt;
    logic [XLEN-1:0]    instr;
    logic [XLEN-1:0]    pc;
    logic               misaligned;
    logic               req;
    logic               exec_en;
    logic               fault;

    switch_mcu_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (in_clk),
        .rst        (in_rst),
        .capture    (state == ST_EXEC),
        .commit     (state == ST_NEXT),
        .wen        (in_pc_wen),
        .wdata      (in_pc_wdata),
        .pc         (pc),
        .misaligned (misaligned)
    );

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        exec_en   = 1'b0;
        fault     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_run) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                req = 1'b1;
                if (in_imem_ack) state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                exec_en = 1'b1;
                // The final count value is held exactly one cycle before NEXT.
                if (cnt == LAST_CNT) state_nxt = ST_NEXT;
            end
            ST_NEXT: begin
                if (misaligned)  state_nxt = ST_FAULT;
                else if (in_run) state_nxt = ST_FETCH;
                else             state_nxt = ST_IDLE;
            end
            ST_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Cycle counter and instruction latch.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            cnt   <= '0;
            instr <= '0;
        end else begin
            if ((state == ST_FETCH) && in_imem_ack) begin
                instr <= in_imem_rdata;
            end
            case (state)
                ST_DECODE: cnt <= CYCLE_W'(1);
                ST_EXEC:   cnt <= (cnt == LAST_CNT) ? '0 : cnt + CYCLE_W'(1);
                default:   cnt <= '0;
            endcase
        end
    end

    assign out_imem_req  = req;
    assign out_imem_addr = pc;
    assign out_instr     = instr;
    assign out_exec_en   = exec_en;
    assign out_cycle_cnt = cnt;
    assign out_pc        = pc;
    assign out_fault     = fault;

endmodule

// File: tb/tb_switch_mcu_sequencer.sv
// Purpose : self-checking bench for switch_mcu_sequencer with an instruction-level reference model.
// Latency : n/a.
// Backpressure : the bench stalls fetch acks to exercise the held request.
module tb_switch_mcu_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          E      = 4;

    logic        clk = 1'b0;
    logic        rst, run, ack, wen;
    logic [31:0] rdata, wdata;
    logic        req, exec_en, fault;
    logic [31:0] addr, instr, pc;
    logic [3:0]  cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc;

    // Observations gathered by run_one for the test tasks to judge.
    logic [31:0] o_fetch_addr, o_dec_instr, o_post_addr, o_post_pc;
    logic        o_wait_ok, o_dec_req, o_instr_ok, o_pc_ok, o_post_req, o_post_fault, o_timeout;
    logic [3:0]  o_dec_cnt, o_next_cnt;
    int          o_cnt_q[$];

    switch_mcu_sequencer #(.RESET_PC(RST_PC), .EXEC_CYCLES(E)) dut (
        .in_clk        (clk),
        .in_rst        (rst),
        .in_run        (run),
        .out_imem_req  (req),
        .out_imem_addr (addr),
        .in_imem_ack   (ack),
        .in_imem_rdata (rdata),
        .out_instr     (instr),
        .out_exec_en   (exec_en),
        .out_cycle_cnt (cnt),
        .in_pc_wen     (wen),
        .in_pc_wdata   (wdata),
        .out_pc        (pc),
        .out_fault     (fault)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: outcome of one instruction from its redirect writes.
    // wa/wb are the count values at which a write happens (0 = none); later count wins.
    function automatic void model(input logic [31:0] cur_pc, input int wa, input logic [31:0] da,
                                  input int wb, input logic [31:0] db,
                                  output logic [31:0] npc, output logic flt);
        logic [31:0] tgt;
        tgt = (wb != 0 && wb >= wa) ? db : ((wa != 0) ? da : db);
        if (wa == 0 && wb == 0) begin
            npc = cur_pc + 32'd4;
            flt = 1'b0;
        end else if (tgt % 4 != 0) begin
            npc = cur_pc;
            flt = 1'b1;
        end else begin
            npc = tgt;
            flt = 1'b0;
        end
    endfunction

    function automatic bit cnt_seq_ok();
        if (o_cnt_q.size() != E) return 1'b0;
        for (int i = 0; i < E; i++) if (o_cnt_q[i] != i + 1) return 1'b0;
        return 1'b1;
    endfunction

    // Drives one instruction from fetch to one cycle after NEXT and records what the DUT did.
    task automatic run_one(input int ack_wait, input logic [31:0] word, input int wa,
                           input logic [31:0] da, input int wb, input logic [31:0] db,
                           input int stop_at);
        int guard;
        o_timeout = 1'b0; o_wait_ok = 1'b1; o_instr_ok = 1'b1; o_pc_ok = 1'b1;
        o_cnt_q.delete();
        guard = 0;
        while (req !== 1'b1 && guard < 20) begin step(); guard++; end
        if (req !== 1'b1) o_timeout = 1'b1;
        o_fetch_addr = addr;
        for (int i = 0; i < ack_wait; i++) begin
            ack = 1'b0; rdata = $urandom;
            step();
            if (req !== 1'b1 || addr !== o_fetch_addr || cnt !== 4'd0 || exec_en !== 1'b0)
                o_wait_ok = 1'b0;
        end
        ack = 1'b1; rdata = word;
        step();
        ack = 1'b0;
        o_dec_req = req; o_dec_instr = instr; o_dec_cnt = cnt;
        guard = 0;
        do begin
            step();
            guard++;
            if (exec_en === 1'b1) begin
                o_cnt_q.push_back(int'(cnt));
                if (instr !== word)       o_instr_ok = 1'b0;
                if (pc !== o_fetch_addr)  o_pc_ok    = 1'b0;
                wen   = (int'(cnt) == wa) || (int'(cnt) == wb);
                wdata = (int'(cnt) == wb) ? db : ((int'(cnt) == wa) ? da : $urandom);
                // Stray acks outside FETCH must be ignored.
                ack   = 1'($urandom_range(0, 1));
                rdata = $urandom;
                if (int'(cnt) == stop_at) run = 1'b0;
            end
        end while (exec_en === 1'b1 && guard < 40);
        if (guard >= 40) o_timeout = 1'b1;
        wen = 1'b0; ack = 1'b0;
        o_next_cnt = cnt;
        step();
        o_post_req = req; o_post_addr = addr; o_post_fault = fault; o_post_pc = pc;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0;
        step();
        rst = 1'b0;
        checks++; if (pc !== RST_PC)    begin errors++; $display("FAIL reset_pc: got %h want %h", pc, RST_PC); end
        checks++; if (addr !== RST_PC)  begin errors++; $display("FAIL reset_addr: got %h want %h", addr, RST_PC); end
        checks++; if (instr !== 32'h0)  begin errors++; $display("FAIL reset_instr: got %h want 0", instr); end
        checks++; if (req !== 1'b0)     begin errors++; $display("FAIL reset_req: got %b want 0", req); end
        checks++; if (exec_en !== 1'b0) begin errors++; $display("FAIL reset_exec_en: got %b want 0", exec_en); end
        checks++; if (cnt !== 4'd0)     begin errors++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
        checks++; if (fault !== 1'b0)   begin errors++; $display("FAIL reset_fault: got %b want 0", fault); end
        step(); step();
        checks++; if (req !== 1'b0)     begin errors++; $display("FAIL idle_no_req: got %b want 0", req); end
        run = 1'b1;
        step();
        checks++; if (req !== 1'b1)     begin errors++; $display("FAIL idle_to_fetch: got %b want 1", req); end
        m_pc = RST_PC;
    endtask

    task automatic test_basic();
        logic [31:0] w, npc; logic flt;
        w = $urandom;
        model(m_pc, 0, 0, 0, 0, npc, flt);
        run_one(0, w, 0, 0, 0, 0, 0);
        checks++; if (o_timeout)               begin errors++; $display("FAIL basic_timeout: got 1 want 0"); end
        checks++; if (o_fetch_addr !== m_pc)   begin errors++; $display("FAIL basic_fetch_addr: got %h want %h", o_fetch_addr, m_pc); end
        checks++; if (o_dec_req !== 1'b0)      begin errors++; $display("FAIL basic_req_drop: got %b want 0", o_dec_req); end
        checks++; if (o_dec_cnt !== 4'd0)      begin errors++; $display("FAIL basic_decode_cnt: got %0d want 0", o_dec_cnt); end
        checks++; if (!cnt_seq_ok())           begin errors++; $display("FAIL basic_cnt_seq: got %0d exec cycles want %0d counting 1..%0d", o_cnt_q.size(), E, E); end
        checks++; if (o_next_cnt !== 4'd0)     begin errors++; $display("FAIL basic_next_cnt: got %0d want 0", o_next_cnt); end
        checks++; if (o_post_req !== 1'b1)     begin errors++; $display("FAIL basic_next_req: got %b want 1", o_post_req); end
        checks++; if (o_post_addr !== npc)     begin errors++; $display("FAIL basic_next_addr: got %h want %h", o_post_addr, npc); end
        m_pc = npc;
    endtask

    task automatic test_fetch_stall();
        logic [31:0] npc; logic flt;
        model(m_pc, 0, 0, 0, 0, npc, flt);
        run_one(5, 32'h0050_0513, 0, 0, 0, 0, 0);
        checks++; if (!o_wait_ok)                   begin errors++; $display("FAIL stall_hold: req/addr/cnt not held while ack low"); end
        checks++; if (o_fetch_addr !== m_pc)        begin errors++; $display("FAIL stall_addr: got %h want %h", o_fetch_addr, m_pc); end
        checks++; if (o_dec_instr !== 32'h0050_0513) begin errors++; $display("FAIL stall_decode_instr: got %h want 00500513", o_dec_instr); end
        checks++; if (!o_instr_ok || !o_pc_ok)      begin errors++; $display("FAIL stall_instr_stable: instr_ok=%b pc_ok=%b want 1", o_instr_ok, o_pc_ok); end
        checks++; if (o_post_addr !== npc)          begin errors++; $display("FAIL stall_next_addr: got %h want %h", o_post_addr, npc); end
        m_pc = npc;
    endtask

    task automatic test_redirect_overwrite();
        logic [31:0] npc; logic flt;
        model(m_pc, 2, 32'h100, 3, 32'h200, npc, flt);
        run_one(0, $urandom, 2, 32'h100, 3, 32'h200, 0);
        checks++; if (o_post_addr !== npc)  begin errors++; $display("FAIL redirect_last_wins: got %h want %h", o_post_addr, npc); end
        checks++; if (o_post_fault !== flt) begin errors++; $display("FAIL redirect_fault: got %b want %b", o_post_fault, flt); end
        m_pc = npc;
    endtask

    task automatic test_random();
        logic [31:0] w, da, db, npc; logic flt;
        int wa, wb, aw;
        for (int n = 0; n < 25; n++) begin
            w  = $urandom;
            aw = $urandom_range(0, 3);
            wa = $urandom_range(0, E);
            wb = $urandom_range(0, E);
            da = $urandom & 32'hFFFF_FFFC;
            db = $urandom & 32'hFFFF_FFFC;
            model(m_pc, wa, da, wb, db, npc, flt);
            run_one(aw, w, wa, da, wb, db, 0);
            checks++; if (o_timeout || !o_wait_ok) begin errors++; $display("FAIL rand_handshake[%0d]: timeout=%b wait_ok=%b", n, o_timeout, o_wait_ok); end
            checks++; if (o_fetch_addr !== m_pc)   begin errors++; $display("FAIL rand_fetch_addr[%0d]: got %h want %h", n, o_fetch_addr, m_pc); end
            checks++; if (!cnt_seq_ok())           begin errors++; $display("FAIL rand_cnt_seq[%0d]: got %0d exec cycles want %0d", n, o_cnt_q.size(), E); end
            checks++; if (o_dec_instr !== w || !o_instr_ok) begin errors++; $display("FAIL rand_instr[%0d]: got %h want %h", n, o_dec_instr, w); end
            checks++; if (o_post_addr !== npc || o_post_req !== 1'b1) begin errors++; $display("FAIL rand_next[%0d]: got addr %h req %b want %h 1", n, o_post_addr, o_post_req, npc); end
            m_pc = npc;
        end
    endtask

    task automatic test_wrap();
        logic [31:0] npc; logic flt;
        run_one(0, $urandom, $urandom_range(1, E), 32'hFFFF_FFFC, 0, 0, 0);
        checks++; if (o_post_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup: got %h want fffffffc", o_post_addr); end
        m_pc = 32'hFFFF_FFFC;
        model(m_pc, 0, 0, 0, 0, npc, flt);
        run_one(1, $urandom, 0, 0, 0, 0, 0);
        checks++; if (o_post_addr !== npc) begin errors++; $display("FAIL wrap_addr: got %h want %h", o_post_addr, npc); end
        m_pc = npc;
    endtask

    task automatic test_stop_and_reset();
        logic seen_req;
        int guard;
        run_one(0, $urandom, 0, 0, 0, 0, 2);
        checks++; if (o_post_req !== 1'b0)       begin errors++; $display("FAIL stop_no_req: got %b want 0", o_post_req); end
        checks++; if (o_post_pc !== m_pc + 32'd4) begin errors++; $display("FAIL stop_pc: got %h want %h", o_post_pc, m_pc + 32'd4); end
        seen_req = 1'b0;
        for (int i = 0; i < 3; i++) begin step(); if (req !== 1'b0) seen_req = 1'b1; end
        checks++; if (seen_req !== 1'b0)         begin errors++; $display("FAIL stop_idle: req seen while stopped"); end
        // Restart and reset in the middle of execute.
        run = 1'b1;
        step();
        ack = 1'b1; rdata = $urandom;
        step();
        ack = 1'b0;
        guard = 0;
        while (cnt !== 4'd3 && guard < 20) begin step(); guard++; end
        checks++; if (cnt !== 4'd3)              begin errors++; $display("FAIL midexec_reach: got cnt %0d want 3", cnt); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (req !== 1'b0 || exec_en !== 1'b0 || cnt !== 4'd0 || fault !== 1'b0)
            begin errors++; $display("FAIL midexec_reset_strobes: got req %b en %b cnt %0d fault %b want 0", req, exec_en, cnt, fault); end
        checks++; if (pc !== RST_PC || addr !== RST_PC || instr !== 32'h0)
            begin errors++; $display("FAIL midexec_reset_regs: got pc %h addr %h instr %h want %h %h 0", pc, addr, instr, RST_PC, RST_PC); end
        m_pc = RST_PC;
    endtask

    task automatic test_fault();
        logic [31:0] npc; logic flt;
        logic bad;
        run = 1'b1;
        model(m_pc, 2, 32'h102, 0, 0, npc, flt);
        run_one(0, $urandom, 2, 32'h102, 0, 0, 0);
        checks++; if (o_post_fault !== flt) begin errors++; $display("FAIL fault_flag: got %b want %b", o_post_fault, flt); end
        checks++; if (o_post_req !== 1'b0)  begin errors++; $display("FAIL fault_no_req: got %b want 0", o_post_req); end
        checks++; if (o_post_pc !== npc)    begin errors++; $display("FAIL fault_pc_hold: got %h want %h", o_post_pc, npc); end
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ack = 1'b1;
            step();
            if (req !== 1'b0 || exec_en !== 1'b0 || fault !== 1'b1) bad = 1'b1;
        end
        ack = 1'b0;
        checks++; if (bad !== 1'b0)         begin errors++; $display("FAIL fault_terminal: strobes active or flag cleared in FAULT"); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (pc !== RST_PC || fault !== 1'b0) begin errors++; $display("FAIL fault_reset: got pc %h fault %b want %h 0", pc, fault, RST_PC); end
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; ack = 1'b0; wen = 1'b0; rdata = '0; wdata = '0;
        m_pc = RST_PC;
        test_reset();
        test_basic();
        test_fetch_stall();
        test_redirect_overwrite();
        test_random();
        test_wrap();
        test_stop_and_reset();
        test_fault();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
